// File: rtl/fifo_pop_ctrl_if.sv
// Bundle of the command, FIFO-read and downstream-stream signals around fifo_pop_ctrl.
// slave is the controller's view; master is the surrounding logic (FIFO, command source, consumer).
interface fifo_pop_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int LENW  = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LENW-1:0]  cmd_len;
    logic             abort;
    logic             pop_req;
    logic             pop_ack;
    logic [WIDTH-1:0] fifo_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             done;
    logic             aborted;
    logic [LENW-1:0]  xfer_cnt;

    modport slave (
        input  cmd_valid, cmd_len, abort, pop_ack, fifo_data, out_ready,
        output cmd_ready, pop_req, out_valid, out_data, out_last, done, aborted, xfer_cnt
    );

    modport master (
        output cmd_valid, cmd_len, abort, pop_ack, fifo_data, out_ready,
        input  cmd_ready, pop_req, out_valid, out_data, out_last, done, aborted, xfer_cnt
    );
endinterface

// File: rtl/fifo_pop_ctrl.sv
// Pops exactly cmd_len words from a FIFO and streams them out through a one-word output
// register, flagging the last word and reporting done/aborted plus a delivered-word count.
module fifo_pop_ctrl #(
    parameter int WIDTH = 32,
    parameter int LENW  = 8
) (
    input  logic          clk,
    input  logic          reset,
    fifo_pop_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LENW-1:0]  remaining_q, remaining_d;
    logic [LENW-1:0]  xfer_cnt_q, xfer_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic cmd_ready, pop_req, cmd_fire, pop_fire, out_fire;

    assign cmd_ready = (state_q == S_IDLE) & ~reset;
    // Pop only when the output register is free or emptying this cycle; reset holds the
    // FIFO untouched so no word is lost from it while the controller is being cleared.
    assign pop_req  = (state_q == S_READ) & (remaining_q != '0) & ~bus.abort
                    & (~out_valid_q | bus.out_ready) & ~reset;
    assign cmd_fire = bus.cmd_valid & cmd_ready;
    assign pop_fire = pop_req & bus.pop_ack;
    assign out_fire = out_valid_q & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        xfer_cnt_d  = xfer_cnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        if (out_fire) begin
            xfer_cnt_d  = xfer_cnt_q + LENW'(1);
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    remaining_d = bus.cmd_len;
                    xfer_cnt_d  = '0;
                    if (bus.cmd_len != '0) state_d = S_READ;
                    else                   done_d  = 1'b1;
                end
            end
            S_READ, S_DRAIN: begin
                if (bus.abort) begin
                    // Handshake above still counts; the held word is dropped.
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    aborted_d   = 1'b1;
                end else if (pop_fire) begin
                    out_data_d  = bus.fifo_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == LENW'(1));
                    remaining_d = remaining_q - LENW'(1);
                    if (remaining_q == LENW'(1)) state_d = S_DRAIN;
                end else if ((state_q == S_DRAIN) && out_fire && out_last_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            xfer_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            xfer_cnt_q  <= xfer_cnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.pop_req   = pop_req;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign bus.xfer_cnt  = xfer_cnt_q;
endmodule

// File: doc/fifo_pop_ctrl.md
Name: fifo_pop_ctrl

Overview:
Read-side companion to the FIFO controller. It accepts a read command for N words and pops exactly N words from the FIFO using the FIFO's pop_req/pop_ack interface. Each popped word is registered and presented on a downstream valid/ready stream, with a last marker on the final word. A done pulse and a transfer count are reported at the end. The block sits between the FIFO's read port and a consumer such as a DMA or bus-write engine.

Parameters:
WIDTH, 32, data word width; must match the FIFO WIDTH.
LENW, 8, width of cmd_len and xfer_cnt; the maximum command length is 2^LENW-1.

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  read command request
cmd_ready  out  1  block can accept a command
cmd_len  in  LENW  number of words to read; 0 is legal
abort  in  1  terminate the current command
pop_req  out  1  pop request to the FIFO
pop_ack  in  1  FIFO non-empty; a pop occurs at a clock edge when pop_req & pop_ack
fifo_data  in  WIDTH  FIFO head word, valid when pop_ack=1
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts the word
out_data  out  WIDTH  popped word
out_last  out  1  qualifies the final word of the command
done  out  1  one-cycle completion pulse
aborted  out  1  one-cycle pulse coincident with done when the command ended by abort
xfer_cnt  out  LENW  words handed downstream for the current or last command

Behaviour:
- Interface decisions: one clock, clk. Reset is synchronous and active-high, on port reset.
- State machine: IDLE, READ, DRAIN.
- Reset:
  - state=IDLE.
  - out_valid, out_last, out_data, done, aborted, xfer_cnt and the internal remaining counter are all 0.
  - cmd_ready=0 while reset is high.
- cmd_ready = (state==IDLE) & ~reset.
- Command accept (cmd_valid & cmd_ready at an edge):
  - Latch remaining=cmd_len and clear xfer_cnt.
  - If cmd_len!=0: go to READ.
  - If cmd_len==0: stay in IDLE and pulse done the next cycle. No pop occurs.
- pop_req = (state==READ) & (remaining!=0) & ~abort & (~out_valid | out_ready). It is combinational.
- Pop edge (pop_req & pop_ack):
  - out_data<=fifo_data and out_valid<=1.
  - out_last<=(remaining==1).
  - remaining<=remaining-1.
  - If remaining==1, go to DRAIN.
- Latency: a word at the FIFO head appears on out_data one cycle after its pop. Back-to-back pops sustain 1 word/cycle while out_ready=1 and the FIFO is non-empty.
- FIFO empty (pop_ack=0): pop_req stays high in READ and the block waits indefinitely. No timeout.
- Output handshake (out_valid & out_ready):
  - xfer_cnt increments.
  - out_valid<=0 unless a new pop occurs at the same edge.
  - out_data and out_last are held stable while out_valid & ~out_ready.
- DRAIN: on the handshake of the word with out_last=1, go to IDLE with done<=1 for one cycle. cmd_ready is high in that same done cycle.
- Abort (sampled only in READ or DRAIN):
  - At that edge: state<=IDLE, out_valid<=0, out_last<=0, done<=1, aborted<=1.
  - The pop is suppressed in the abort cycle, so no word is removed from the FIFO.
  - An output handshake in the abort cycle still counts in xfer_cnt.
  - The word held in the output register is discarded.
  - Abort in IDLE is ignored.
- done/aborted: registered, high for exactly one cycle, low otherwise.
- xfer_cnt: holds after done until the next command accept.
- Arithmetic:
  - remaining and xfer_cnt are LENW bits.
  - xfer_cnt never exceeds the accepted cmd_len.
  - No wrap occurs, because remaining gates the pops.
- Reset mid-operation: everything returns to reset values next cycle, with no done pulse. Words already popped but not delivered are lost. Words still in the FIFO are untouched by this block.

Test Plan:
1. FIFO preloaded 0xA0,0xA1,0xA2,0xA3; cmd_len=4; out_ready=1 -> four pops on consecutive cycles; out_data A0..A3 back-to-back; out_last only with A3; done one cycle after the A3 handshake; xfer_cnt=4; FIFO empty.
2. cmd_len=3, FIFO holds 3 words, out_ready low for 3 cycles after the first word -> pop_req=0 during the stall; out_data=first word held; remaining words delivered in order afterwards; no drops or duplicates.
3. cmd_len=3, FIFO holds 1 word, the next two pushed 5 cycles later -> pop_req stays high through the empty period; pops resume on push; order preserved; done after the third handshake.
4. cmd_len=0 -> done pulse next cycle, aborted=0, no pop_req, xfer_cnt=0, cmd_ready stays high.
5. cmd_len=5, FIFO holds 5 words, abort asserted after the 2nd handshake -> done=aborted=1 for one cycle; out_valid=0; xfer_cnt=2; FIFO still holds 5 minus pops performed; new command accepted next cycle.
6. Reset for 1 cycle during a transfer -> all outputs 0 next cycle, no done pulse, cmd_ready=1 after release; a new cmd_len=2 completes normally.
